// File: rtl/turf_event_ctrl_pkg.sv
// Shared definitions for the TURF event-control initiator: command codes,
// request length and FSM state encoding.
package turf_event_ctrl_pkg;

    // Two-character ASCII command codes (first character in the upper byte).
    localparam logic [15:0] CMD_OP = 16'h4F50;
    localparam logic [15:0] CMD_CL = 16'h434C;
    localparam logic [15:0] CMD_ID = 16'h4944;
    localparam logic [15:0] CMD_PR = 16'h5052;
    localparam logic [15:0] CMD_PW = 16'h5057;
    localparam logic [15:0] CMD_PX = 16'h5058;
    localparam logic [15:0] CMD_ES = 16'h4553;

    // UDP length field of every request (one 8-byte payload word plus header).
    localparam logic [15:0] UDP_LEN = 16'd16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_HDR  = 3'd1,
        SEND_DATA = 3'd2,
        WAIT_RSP  = 3'd3,
        RX_DATA   = 3'd4,
        DUMP      = 3'd5,
        DONE      = 3'd6
    } state_e;

    // Saturating increment for 16-bit event counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/turf_event_ctrl_initiator.sv
// TURF event-control initiator: sends one command over UDP, waits for the
// matching reply with per-attempt timeout and bounded retransmission, and
// drains stray or non-matching packets.
// Optional build macro TURF_EVCTRL_INITIATOR_STATS_EN adds saturating
// retry / timeout / stray-packet counters.
module turf_event_ctrl_initiator
    import turf_event_ctrl_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
    parameter int          MAX_RETRIES    = 3,
    parameter string       DEBUG          = "FALSE"
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_code,
    input  logic [47:0] cmd_payload,
    input  logic [31:0] cmd_ip,
    input  logic [15:0] cmd_port,
    output logic        m_udphdr_tvalid,
    input  logic        m_udphdr_tready,
    output logic [63:0] m_udphdr_tdata,
    output logic        m_udpdata_tvalid,
    input  logic        m_udpdata_tready,
    output logic [63:0] m_udpdata_tdata,
    output logic [7:0]  m_udpdata_tkeep,
    output logic        m_udpdata_tlast,
    input  logic        s_udphdr_tvalid,
    output logic        s_udphdr_tready,
    input  logic [63:0] s_udphdr_tdata,
    input  logic        s_udpdata_tvalid,
    output logic        s_udpdata_tready,
    input  logic [63:0] s_udpdata_tdata,
    input  logic [7:0]  s_udpdata_tkeep,
    input  logic        s_udpdata_tlast,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
`ifdef TURF_EVCTRL_INITIATOR_STATS_EN
    ,
    output logic [15:0] stat_retries,
    output logic [15:0] stat_timeouts,
    output logic [15:0] stat_stray
`endif
);

    localparam logic [23:0] TMO_LAST_C  = TIMEOUT_CYCLES - 24'd1;
    localparam logic [7:0]  RETRY_MAX_C = 8'(MAX_RETRIES);

    state_e      state_r;
    state_e      state_nxt_s;
    logic [63:0] word_r;
    logic [31:0] tgt_ip_r;
    logic [15:0] tgt_port_r;
    logic [31:0] src_ip_r;
    logic [15:0] src_port_r;
    logic [23:0] tmo_cnt_r;
    logic [7:0]  retry_cnt_r;
    logic        done_pend_r;
    logic        busy_r;
    logic [63:0] rsp_data_r;
    logic        rsp_timeout_r;

    logic        accept_s;
    logic        hdr_cap_s;
    logic        retry_ev_s;
    logic        tmo_ev_s;
    logic        stray_ev_s;
    logic        match_ev_s;
    logic        beat_match_s;
    logic        tmo_run_s;
    logic [15:0] unused_hdr_len_s;

    // The UDP length of a reply is not needed to frame it (tlast does that).
    assign unused_hdr_len_s = s_udphdr_tdata[15:0];

    // Reply beat is ours: full word, from the target, echoing the command tag.
    assign beat_match_s = (s_udpdata_tkeep == 8'hFF) &&
                          (src_ip_r == tgt_ip_r) &&
                          (src_port_r == tgt_port_r) &&
                          (s_udpdata_tdata[63:48] == word_r[63:48]);

    assign tmo_run_s = (state_r == WAIT_RSP) || (state_r == RX_DATA) || (state_r == DUMP);

    assign cmd_ready        = (state_r == IDLE);
    assign m_udphdr_tvalid  = (state_r == SEND_HDR);
    assign m_udphdr_tdata   = {tgt_ip_r, tgt_port_r, UDP_LEN};
    assign m_udpdata_tvalid = (state_r == SEND_DATA);
    assign m_udpdata_tdata  = word_r;
    assign m_udpdata_tkeep  = 8'hFF;
    assign m_udpdata_tlast  = 1'b1;
    assign s_udphdr_tready  = (state_r == WAIT_RSP) || ((state_r == IDLE) && !cmd_valid);
    assign s_udpdata_tready = (state_r == RX_DATA) || (state_r == DUMP);
    assign rsp_valid        = (state_r == DONE);
    assign rsp_data         = rsp_data_r;
    assign rsp_timeout      = rsp_timeout_r;
    assign busy             = busy_r;

    // Hook for an on-chip logic analyser in debug builds; nothing is added otherwise.
    if (DEBUG == "TRUE") begin : g_debug_ila
    end

    // Next-state and event decode for the request/response FSM.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        hdr_cap_s   = 1'b0;
        retry_ev_s  = 1'b0;
        tmo_ev_s    = 1'b0;
        stray_ev_s  = 1'b0;
        match_ev_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = SEND_HDR;
                end else if (s_udphdr_tvalid) begin
                    stray_ev_s  = 1'b1;
                    state_nxt_s = DUMP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND_HDR: begin
                if (m_udphdr_tready) begin
                    state_nxt_s = SEND_DATA;
                end else begin
                    state_nxt_s = SEND_HDR;
                end
            end
            SEND_DATA: begin
                if (m_udpdata_tready) begin
                    state_nxt_s = WAIT_RSP;
                end else begin
                    state_nxt_s = SEND_DATA;
                end
            end
            WAIT_RSP: begin
                if (s_udphdr_tvalid) begin
                    hdr_cap_s   = 1'b1;
                    state_nxt_s = RX_DATA;
                end else if (tmo_cnt_r >= TMO_LAST_C) begin
                    if (retry_cnt_r < RETRY_MAX_C) begin
                        retry_ev_s  = 1'b1;
                        state_nxt_s = SEND_HDR;
                    end else begin
                        tmo_ev_s    = 1'b1;
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = WAIT_RSP;
                end
            end
            RX_DATA: begin
                if (s_udpdata_tvalid) begin
                    if (beat_match_s) begin
                        match_ev_s  = 1'b1;
                        state_nxt_s = s_udpdata_tlast ? DONE : DUMP;
                    end else begin
                        stray_ev_s  = 1'b1;
                        state_nxt_s = s_udpdata_tlast ? WAIT_RSP : DUMP;
                    end
                end else begin
                    state_nxt_s = RX_DATA;
                end
            end
            DUMP: begin
                if (s_udpdata_tvalid && s_udpdata_tlast) begin
                    if (done_pend_r) begin
                        state_nxt_s = DONE;
                    end else if (busy_r) begin
                        state_nxt_s = WAIT_RSP;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = DUMP;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command latch, reply source capture and response result registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            word_r        <= 64'd0;
            tgt_ip_r      <= 32'd0;
            tgt_port_r    <= 16'd0;
            src_ip_r      <= 32'd0;
            src_port_r    <= 16'd0;
            rsp_data_r    <= 64'd0;
            rsp_timeout_r <= 1'b0;
            done_pend_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            if (accept_s) begin
                word_r        <= {cmd_payload, cmd_code};
                tgt_ip_r      <= cmd_ip;
                tgt_port_r    <= cmd_port;
                rsp_data_r    <= 64'd0;
                rsp_timeout_r <= 1'b0;
                done_pend_r   <= 1'b0;
                busy_r        <= 1'b1;
            end else if (state_r == DONE) begin
                done_pend_r   <= 1'b0;
                busy_r        <= 1'b0;
            end
            if (hdr_cap_s) begin
                src_ip_r   <= s_udphdr_tdata[63:32];
                src_port_r <= s_udphdr_tdata[31:16];
            end
            if (match_ev_s) begin
                rsp_data_r  <= s_udpdata_tdata;
                done_pend_r <= !s_udpdata_tlast;
            end
            if (tmo_ev_s) begin
                rsp_timeout_r <= 1'b1;
                rsp_data_r    <= 64'd0;
            end
        end
    end

    // Per-attempt response timer (saturating) and retransmission counter.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tmo_cnt_r   <= 24'd0;
            retry_cnt_r <= 8'd0;
        end else begin
            if ((state_r == SEND_DATA) && m_udpdata_tready) begin
                tmo_cnt_r <= 24'd0;
            end else if (tmo_run_s && (tmo_cnt_r < TMO_LAST_C)) begin
                tmo_cnt_r <= tmo_cnt_r + 24'd1;
            end
            if (accept_s) begin
                retry_cnt_r <= 8'd0;
            end else if (retry_ev_s) begin
                retry_cnt_r <= retry_cnt_r + 8'd1;
            end
        end
    end

`ifdef TURF_EVCTRL_INITIATOR_STATS_EN
    logic [15:0] stat_retries_r;
    logic [15:0] stat_timeouts_r;
    logic [15:0] stat_stray_r;

    assign stat_retries  = stat_retries_r;
    assign stat_timeouts = stat_timeouts_r;
    assign stat_stray    = stat_stray_r;

    // Saturating event statistics.
    always_ff @(posedge aclk) begin
        if (areset) begin
            stat_retries_r  <= 16'd0;
            stat_timeouts_r <= 16'd0;
            stat_stray_r    <= 16'd0;
        end else begin
            if (retry_ev_s) begin
                stat_retries_r <= sat_inc16(stat_retries_r);
            end
            if (tmo_ev_s) begin
                stat_timeouts_r <= sat_inc16(stat_timeouts_r);
            end
            if (stray_ev_s) begin
                stat_stray_r <= sat_inc16(stat_stray_r);
            end
        end
    end
`endif

endmodule

// File: tb/tb_turf_event_ctrl_initiator.sv
// Directed bench for turf_event_ctrl_initiator: a table of request/reply
// scenarios on a long-timeout instance plus hand-written sequences for
// back-pressure, stray packets, reset and retry/timeout on a short-timeout instance.
module tb_turf_event_ctrl_initiator;
    import turf_event_ctrl_pkg::*;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        areset;
    logic [15:0] cmd_code;
    logic [47:0] cmd_payload;
    logic [31:0] cmd_ip;
    logic [15:0] cmd_port;
    // instance A (default timeout)
    logic        cmd_valid_a, cmd_ready_a;
    logic        m_hdr_valid_a, m_hdr_ready_a;
    logic [63:0] m_hdr_data_a;
    logic        m_dat_valid_a, m_dat_ready_a, m_dat_last_a;
    logic [63:0] m_dat_data_a;
    logic [7:0]  m_dat_keep_a;
    logic        s_hdr_valid, s_hdr_ready_a;
    logic [63:0] s_hdr_data;
    logic        s_dat_valid, s_dat_ready_a, s_dat_last;
    logic [63:0] s_dat_data;
    logic [7:0]  s_dat_keep;
    logic        rsp_valid_a, rsp_timeout_a, busy_a;
    logic [63:0] rsp_data_a;
    // instance B (short timeout, nobody answers)
    logic        cmd_valid_b, cmd_ready_b;
    logic        m_hdr_valid_b, m_dat_valid_b, m_dat_last_b;
    logic [63:0] m_hdr_data_b, m_dat_data_b;
    logic [7:0]  m_dat_keep_b;
    logic        s_hdr_ready_b, s_dat_ready_b;
    logic        rsp_valid_b, rsp_timeout_b, busy_b;
    logic [63:0] rsp_data_b;
`ifdef TURF_EVCTRL_INITIATOR_STATS_EN
    logic [15:0] st_retries_a, st_timeouts_a, st_stray_a;
    logic [15:0] st_retries_b, st_timeouts_b, st_stray_b;
`endif

    turf_event_ctrl_initiator dut_a (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_code(cmd_code),
        .cmd_payload(cmd_payload), .cmd_ip(cmd_ip), .cmd_port(cmd_port),
        .m_udphdr_tvalid(m_hdr_valid_a), .m_udphdr_tready(m_hdr_ready_a), .m_udphdr_tdata(m_hdr_data_a),
        .m_udpdata_tvalid(m_dat_valid_a), .m_udpdata_tready(m_dat_ready_a), .m_udpdata_tdata(m_dat_data_a),
        .m_udpdata_tkeep(m_dat_keep_a), .m_udpdata_tlast(m_dat_last_a),
        .s_udphdr_tvalid(s_hdr_valid), .s_udphdr_tready(s_hdr_ready_a), .s_udphdr_tdata(s_hdr_data),
        .s_udpdata_tvalid(s_dat_valid), .s_udpdata_tready(s_dat_ready_a), .s_udpdata_tdata(s_dat_data),
        .s_udpdata_tkeep(s_dat_keep), .s_udpdata_tlast(s_dat_last),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_timeout(rsp_timeout_a), .busy(busy_a)
`ifdef TURF_EVCTRL_INITIATOR_STATS_EN
        , .stat_retries(st_retries_a), .stat_timeouts(st_timeouts_a), .stat_stray(st_stray_a)
`endif
    );

    turf_event_ctrl_initiator #(.TIMEOUT_CYCLES(24'd64), .MAX_RETRIES(2)) dut_b (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_code(cmd_code),
        .cmd_payload(cmd_payload), .cmd_ip(cmd_ip), .cmd_port(cmd_port),
        .m_udphdr_tvalid(m_hdr_valid_b), .m_udphdr_tready(1'b1), .m_udphdr_tdata(m_hdr_data_b),
        .m_udpdata_tvalid(m_dat_valid_b), .m_udpdata_tready(1'b1), .m_udpdata_tdata(m_dat_data_b),
        .m_udpdata_tkeep(m_dat_keep_b), .m_udpdata_tlast(m_dat_last_b),
        .s_udphdr_tvalid(1'b0), .s_udphdr_tready(s_hdr_ready_b), .s_udphdr_tdata(64'd0),
        .s_udpdata_tvalid(1'b0), .s_udpdata_tready(s_dat_ready_b), .s_udpdata_tdata(64'd0),
        .s_udpdata_tkeep(8'd0), .s_udpdata_tlast(1'b0),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_timeout(rsp_timeout_b), .busy(busy_b)
`ifdef TURF_EVCTRL_INITIATOR_STATS_EN
        , .stat_retries(st_retries_b), .stat_timeouts(st_timeouts_b), .stat_stray(st_stray_b)
`endif
    );

    // ---------------- bus monitor (samples on the falling edge) ----------------
    int          cyc = 0;
    int          hdr_n_a = 0, dat_n_a = 0, rsp_n_a = 0;
    int          hdr_n_b = 0, dat_n_b = 0, rsp_n_b = 0;
    logic [63:0] hdr_last_a = 64'd0, dat_last_a = 64'd0, rsp_last_a = 64'd0;
    logic [63:0] hdr_last_b = 64'd0, rsp_last_b = 64'd0, dat_last_b = 64'd0;
    logic [8:0]  dat_kl_a = 9'd0, dat_kl_b = 9'd0;
    logic        rsp_to_a = 1'b0, rsp_busy_a = 1'b0, rsp_to_b = 1'b0;
    int          dat_cyc_b [16];
    int          rsp_cyc_b = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (m_hdr_valid_a && m_hdr_ready_a) begin
            hdr_n_a <= hdr_n_a + 1; hdr_last_a <= m_hdr_data_a;
        end
        if (m_dat_valid_a && m_dat_ready_a) begin
            dat_n_a <= dat_n_a + 1; dat_last_a <= m_dat_data_a; dat_kl_a <= {m_dat_keep_a, m_dat_last_a};
        end
        if (rsp_valid_a) begin
            rsp_n_a <= rsp_n_a + 1; rsp_last_a <= rsp_data_a; rsp_to_a <= rsp_timeout_a; rsp_busy_a <= busy_a;
        end
        if (m_hdr_valid_b) begin
            hdr_n_b <= hdr_n_b + 1; hdr_last_b <= m_hdr_data_b;
        end
        if (m_dat_valid_b) begin
            dat_n_b <= dat_n_b + 1; dat_last_b <= m_dat_data_b; dat_kl_b <= {m_dat_keep_b, m_dat_last_b};
            dat_cyc_b[dat_n_b[3:0]] <= cyc;
        end
        if (rsp_valid_b) begin
            rsp_n_b <= rsp_n_b + 1; rsp_last_b <= rsp_data_b; rsp_to_b <= rsp_timeout_b; rsp_cyc_b <= cyc;
        end
    end

    // ---------------- checking helpers ----------------
    int checks_n = 0;
    int errors_n = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks_n++;
        if (act !== req) begin
            errors_n++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic issue_cmd(input logic [15:0] code, input logic [47:0] pl, input logic [31:0] ip,
                             input logic [15:0] port, input bit to_b, output bit ok);
        cmd_code = code; cmd_payload = pl; cmd_ip = ip; cmd_port = port;
        if (to_b) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if ((to_b ? cmd_ready_b : cmd_ready_a) == 1'b1) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    endtask

    // Reply packet into instance A: header, then `beats` data beats.
    task automatic send_pkt(input logic [31:0] ip, input logic [15:0] port, input int beats,
                            input logic [63:0] d0, input logic [7:0] k0, output bit ok);
        bit got;
        s_hdr_data = {ip, port, 16'(8 + beats * 8)};
        s_hdr_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (s_hdr_ready_a) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        s_hdr_valid = 1'b0;
        for (int b = 0; b < beats; b++) begin
            s_dat_valid = 1'b1;
            s_dat_data  = d0 + 64'(b);
            s_dat_keep  = (b == 0) ? k0 : 8'hFF;
            s_dat_last  = (b == beats - 1);
            got = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge aclk);
                if (s_dat_ready_a) begin got = 1'b1; break; end
            end
            if (!got) ok = 1'b0;
            @(posedge aclk); #1;
        end
        s_dat_valid = 1'b0; s_dat_last = 1'b0;
    endtask

    task automatic wait_cnt_a(input bit rsp, input int snap, input int limit, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge aclk); #1;
            if ((rsp ? rsp_n_a : dat_n_a) > snap) begin seen = 1'b1; break; end
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] code;   logic [47:0] payload; logic [31:0] ip;  logic [15:0] port;
        logic [31:0] r_ip;   logic [15:0] r_port;  int r_beats;      logic [63:0] r_d0;
        logic [7:0]  r_keep; int r_delay;          logic [63:0] fu_data;
        logic [63:0] exp_hdr; logic [63:0] exp_word; logic [63:0] exp_rsp; int exp_stray;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit ok;
        int hn, dn, rn, rtb;
        logic stable;
`ifdef TURF_EVCTRL_INITIATOR_STATS_EN
        logic [15:0] st0, st1;
`endif
        vecs[0] = '{CMD_PR, 48'h1234_0000_0000, 32'h0A00_0002, 16'd21603, 32'h0A00_0002, 16'd21603, 1,
                    64'h1234_1F9F_0FFF_003F, 8'hFF, 100, 64'd0,
                    64'h0A00_0002_5463_0010, 64'h1234_0000_0000_5052, 64'h1234_1F9F_0FFF_003F, 0};
        vecs[1] = '{CMD_PR, 48'h1234_0000_0000, 32'h0A00_0002, 16'd21603, 32'h0A00_0002, 16'd21604, 1,
                    64'h1234_AAAA_BBBB_CCCC, 8'hFF, 5, 64'h1234_0000_0000_0042,
                    64'h0A00_0002_5463_0010, 64'h1234_0000_0000_5052, 64'h1234_0000_0000_0042, 1};
        vecs[2] = '{CMD_OP, 48'hABCD_0102_0304, 32'hC0A8_0101, 16'h1234, 32'hC0A8_0101, 16'h1234, 3,
                    64'hABCD_5555_6666_7777, 8'hFF, 3, 64'd0,
                    64'hC0A8_0101_1234_0010, 64'hABCD_0102_0304_4F50, 64'hABCD_5555_6666_7777, 0};
        vecs[3] = '{CMD_PW, 48'h00FF_1111_2222, 32'h0A00_0003, 16'd5000, 32'h0A00_0003, 16'd5000, 1,
                    64'h00FF_0000_0000_0001, 8'h0F, 2, 64'h00FF_9999_8888_7777,
                    64'h0A00_0003_1388_0010, 64'h00FF_1111_2222_5057, 64'h00FF_9999_8888_7777, 1};
        vecs[4] = '{CMD_ES, 48'h5A5A_0000_0001, 32'h0A00_0004, 16'h0050, 32'h0A00_0004, 16'h0050, 2,
                    64'h5A5B_0000_0000_0000, 8'hFF, 1, 64'h5A5A_0123_4567_89AB,
                    64'h0A00_0004_0050_0010, 64'h5A5A_0000_0001_4553, 64'h5A5A_0123_4567_89AB, 1};
        vecs[5] = '{CMD_ID, 48'hFFFF_FFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFE, 16'hFFFF, 2,
                    64'hFFFF_0000_0000_0000, 8'hFF, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_0010, 64'hFFFF_FFFF_FFFF_4944, 64'hFFFF_FFFF_FFFF_FFFF, 1};

        areset = 1'b1; cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
        cmd_code = 16'd0; cmd_payload = 48'd0; cmd_ip = 32'd0; cmd_port = 16'd0;
        m_hdr_ready_a = 1'b1; m_dat_ready_a = 1'b1;
        s_hdr_valid = 1'b0; s_hdr_data = 64'd0;
        s_dat_valid = 1'b0; s_dat_data = 64'd0; s_dat_keep = 8'd0; s_dat_last = 1'b0;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;

        // ---- reset state ----
        @(negedge aclk);
        chk("rst_outputs_a", {cmd_ready_a, busy_a, rsp_valid_a, rsp_timeout_a, m_hdr_valid_a, m_dat_valid_a,
                              s_hdr_ready_a, s_dat_ready_a}, 64'b1000_0010);
        chk("rst_rsp_data_a", rsp_data_a, 64'd0);
        chk("rst_hdr_data_a", m_hdr_data_a, 64'h0000_0000_0000_0010);
        chk("rst_outputs_b", {cmd_ready_b, busy_b, rsp_valid_b, s_hdr_ready_b, s_dat_ready_b}, 64'b10010);
        @(posedge aclk); #1;

        // ---- table-driven request/reply scenarios ----
        for (int v = 0; v < 6; v++) begin
            hn = hdr_n_a; dn = dat_n_a; rn = rsp_n_a;
`ifdef TURF_EVCTRL_INITIATOR_STATS_EN
            st0 = st_stray_a;
`endif
            issue_cmd(vecs[v].code, vecs[v].payload, vecs[v].ip, vecs[v].port, 1'b0, ok);
            chk($sformatf("v%0d_cmd_accept", v), 64'(ok), 64'd1);
            @(negedge aclk);
            chk($sformatf("v%0d_hdr_latency", v), {m_hdr_valid_a, busy_a, cmd_ready_a}, 64'b110);
            wait_cnt_a(1'b0, dn, 20, $sformatf("v%0d_data_sent", v));
            @(posedge aclk); #1;
            repeat (vecs[v].r_delay) @(posedge aclk);
            #1;
            send_pkt(vecs[v].r_ip, vecs[v].r_port, vecs[v].r_beats, vecs[v].r_d0, vecs[v].r_keep, ok);
            chk($sformatf("v%0d_reply_hs", v), 64'(ok), 64'd1);
            if (vecs[v].fu_data != 64'd0) begin
                send_pkt(vecs[v].ip, vecs[v].port, 1, vecs[v].fu_data, 8'hFF, ok);
                chk($sformatf("v%0d_followup_hs", v), 64'(ok), 64'd1);
            end
            wait_cnt_a(1'b1, rn, 50, $sformatf("v%0d_rsp_seen", v));
            repeat (3) @(negedge aclk);
            #1;
            chk($sformatf("v%0d_tx_count", v), {32'(hdr_n_a - hn), 32'(dat_n_a - dn)}, {32'd1, 32'd1});
            chk($sformatf("v%0d_hdr_tdata", v), hdr_last_a, vecs[v].exp_hdr);
            chk($sformatf("v%0d_data_tdata", v), dat_last_a, vecs[v].exp_word);
            chk($sformatf("v%0d_keep_last", v), 64'(dat_kl_a), 64'h1FF);
            chk($sformatf("v%0d_rsp_count", v), 64'(rsp_n_a - rn), 64'd1);
            chk($sformatf("v%0d_rsp_data", v), rsp_last_a, vecs[v].exp_rsp);
            chk($sformatf("v%0d_rsp_to_busy", v), {rsp_to_a, rsp_busy_a}, 64'b01);
            chk($sformatf("v%0d_idle_after", v), {busy_a, cmd_ready_a}, 64'b01);
`ifdef TURF_EVCTRL_INITIATOR_STATS_EN
            chk($sformatf("v%0d_stat_stray", v), 64'(st_stray_a - st0), 64'(vecs[v].exp_stray));
`endif
            @(posedge aclk); #1;
        end

        // ---- header back-pressure: tvalid held, tdata stable ----
        m_hdr_ready_a = 1'b0;
        rn = rsp_n_a; dn = dat_n_a;
        issue_cmd(CMD_PX, 48'h7777_0000_0001, 32'h0A00_0009, 16'h0101, 1'b0, ok);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (!m_hdr_valid_a || m_dat_valid_a || (m_hdr_data_a !== 64'h0A00_0009_0101_0010)) stable = 1'b0;
        end
        chk("bp_hdr_held", 64'(stable), 64'd1);
        @(posedge aclk); #1 m_hdr_ready_a = 1'b1;
        wait_cnt_a(1'b0, dn, 20, "bp_data_sent");
        @(posedge aclk); #1;
        send_pkt(32'h0A00_0009, 16'h0101, 1, 64'h7777_0000_0000_00AA, 8'hFF, ok);
        wait_cnt_a(1'b1, rn, 50, "bp_rsp_seen");
        chk("bp_rsp_data", rsp_last_a, 64'h7777_0000_0000_00AA);
        @(posedge aclk); #1;

        // ---- stray packet while idle and no command: drained, no response ----
        rn = rsp_n_a;
        send_pkt(32'h0B0B_0B0B, 16'h0202, 2, 64'h1111_2222_3333_4444, 8'hFF, ok);
        chk("idle_stray_hs", 64'(ok), 64'd1);
        repeat (5) @(negedge aclk);
        chk("idle_stray_no_rsp", 64'(rsp_n_a - rn), 64'd0);
        chk("idle_stray_back_idle", {cmd_ready_a, busy_a, s_dat_ready_a}, 64'b100);
        @(posedge aclk); #1;

        // ---- stray header together with a command: command wins ----
        rn = rsp_n_a;
        cmd_code = CMD_OP; cmd_payload = 48'hABCD_0102_0304; cmd_ip = 32'hC0A8_0101; cmd_port = 16'h1234;
        s_hdr_data = {32'h0B0B_0B0B, 16'h0101, 16'd32};
        s_hdr_valid = 1'b1; cmd_valid_a = 1'b1;
        @(negedge aclk);
        chk("prio_hdr_ready_low", {s_hdr_ready_a, cmd_ready_a}, 64'b01);
        @(posedge aclk); #1 cmd_valid_a = 1'b0;
        send_pkt(32'h0B0B_0B0B, 16'h0101, 3, 64'hABCD_0000_0000_0000, 8'hFF, ok);
        chk("prio_stray_drained", 64'(ok), 64'd1);
        chk("prio_no_rsp_yet", {64'(rsp_n_a - rn)}, 64'd0);
        send_pkt(32'hC0A8_0101, 16'h1234, 1, 64'hABCD_1111_2222_3333, 8'hFF, ok);
        wait_cnt_a(1'b1, rn, 50, "prio_rsp_seen");
        repeat (3) @(negedge aclk);
        chk("prio_rsp_once", 64'(rsp_n_a - rn), 64'd1);
        chk("prio_rsp_data", rsp_last_a, 64'hABCD_1111_2222_3333);
        @(posedge aclk); #1;

        // ---- reset pulse during WAIT_RSP ----
        rn = rsp_n_a; dn = dat_n_a;
        issue_cmd(CMD_CL, 48'h4242_0000_0000, 32'h0A00_0002, 16'd21603, 1'b0, ok);
        wait_cnt_a(1'b0, dn, 20, "rst_data_sent");
        repeat (10) @(posedge aclk);
        #1 areset = 1'b1;
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        chk("rst_mid_ctrl", {cmd_ready_a, busy_a, rsp_valid_a, rsp_timeout_a, m_hdr_valid_a, m_dat_valid_a},
            64'b100000);
        chk("rst_mid_rsp_data", rsp_data_a, 64'd0);
        repeat (20) @(negedge aclk);
        chk("rst_mid_no_rsp", 64'(rsp_n_a - rn), 64'd0);
        @(posedge aclk); #1;

        // ---- retries then timeout on the short-timeout instance ----
        hn = hdr_n_b; dn = dat_n_b; rtb = rsp_n_b;
`ifdef TURF_EVCTRL_INITIATOR_STATS_EN
        st0 = st_retries_b; st1 = st_timeouts_b;
`endif
        issue_cmd(CMD_PR, 48'h1234_0000_0000, 32'h0A00_0002, 16'd21603, 1'b1, ok);
        chk("to_cmd_accept", 64'(ok), 64'd1);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge aclk); #1;
            if (rsp_n_b > rtb) begin ok = 1'b1; break; end
        end
        chk("to_rsp_seen", 64'(ok), 64'd1);
        repeat (5) @(negedge aclk);
        #1;
        chk("to_tx_count", {32'(hdr_n_b - hn), 32'(dat_n_b - dn)}, {32'd3, 32'd3});
        chk("to_gap1", 64'(dat_cyc_b[(dn + 1) % 16] - dat_cyc_b[dn % 16]), 64'd66);
        chk("to_gap2", 64'(dat_cyc_b[(dn + 2) % 16] - dat_cyc_b[(dn + 1) % 16]), 64'd66);
        chk("to_final_wait", 64'(rsp_cyc_b - dat_cyc_b[(dn + 2) % 16]), 64'd65);
        chk("to_hdr_data", hdr_last_b, 64'h0A00_0002_5463_0010);
        chk("to_beat", dat_last_b, 64'h1234_0000_0000_5052);
        chk("to_keep_last", 64'(dat_kl_b), 64'h1FF);
        chk("to_rsp_once", 64'(rsp_n_b - rtb), 64'd1);
        chk("to_flag", 64'(rsp_to_b), 64'd1);
        chk("to_rsp_data", rsp_last_b, 64'd0);
        chk("to_idle_after", {busy_b, cmd_ready_b}, 64'b01);
`ifdef TURF_EVCTRL_INITIATOR_STATS_EN
        chk("to_stat_retries", 64'(st_retries_b - st0), 64'd2);
        chk("to_stat_timeouts", 64'(st_timeouts_b - st1), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule
